amiv_sram_line_fetch: RTL and testbench

Initiator-side client of the framebuffer SRAM controller. On a line-start command it issues sequential single-word read requests over the controller's start/rw/busy handshake. Returned words are buffered in a show-ahead FIFO that the video output path pops at pixel rate. The block sits between the scan timing generator and the SRAM controller. It is read-only and never requests writes.

---
 rtl/amiv_sram_line_fetch.sv | 163 ++++++++++++++++
 tb/tb_amiv_sram_line_fetch.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/amiv_sram_line_fetch.sv
// Read-only line fetcher: issues sequential single-word SRAM reads on a line-start
// command and buffers the returned words in a show-ahead pixel FIFO.
module amiv_sram_line_fetch #(
    parameter int FIFO_DEPTH = 16,
    parameter int LEN_W      = 11
) (
    input  logic                          in_clk,
    input  logic                          in_reset,
    input  logic                          in_line_start,
    input  logic [18:0]                   in_base_addr,
    input  logic [LEN_W-1:0]              in_line_len,
    output logic                          out_line_busy,
    output logic                          out_line_done,
    input  logic                          in_pop,
    output logic [15:0]                   out_pix_data,
    output logic                          out_pix_valid,
    output logic [$clog2(FIFO_DEPTH):0]   out_fifo_level,
    output logic                          out_underrun,
    output logic                          out_start_n,
    output logic                          out_rw,
    output logic                          out_fast_write,
    output logic [18:0]                   out_addr,
    output logic [15:0]                   out_wr_data,
    input  logic                          in_busy_n,
    input  logic [15:0]                   in_rd_data,
    output logic [2:0]                    out_dbg_state
);

    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE     = 3'd1;
    localparam logic [2:0] S_ACK_WAIT  = 3'd2;
    localparam logic [2:0] S_DONE_WAIT = 3'd3;
    localparam logic [2:0] S_STALL     = 3'd4;

    localparam logic [AW:0]      DEPTH_L = FIFO_DEPTH[AW:0];
    localparam logic [LEN_W-1:0] REM_ONE = 1;

    // Controller handshake: a request is placed by holding start_n low while
    // busy_n is high; busy_n falling acknowledges it, busy_n rising means the
    // read-data register holds the word.
    logic [2:0]       state;
    logic [LEN_W-1:0] rem;
    logic [15:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level;
    logic [AW:0]      level_nxt;
    logic             push;
    logic             pop_eff;
    logic             has_space;

    always_comb begin
        push      = (state == S_DONE_WAIT);
        pop_eff   = in_pop && (level != '0);
        has_space = (level < DEPTH_L);
        level_nxt = level;
        if (push && !pop_eff) begin
            level_nxt = level + 1'b1;
        end else if (!push && pop_eff) begin
            level_nxt = level - 1'b1;
        end
    end

    always_ff @(posedge in_clk) begin
        if (push) begin
            mem[wr_ptr] <= in_rd_data;
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            level        <= '0;
            out_underrun <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_eff) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level        <= level_nxt;
            out_underrun <= in_pop && (level == '0);
        end
    end

    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state         <= S_IDLE;
            rem           <= '0;
            out_addr      <= '0;
            out_start_n   <= 1'b1;
            out_line_busy <= 1'b0;
            out_line_done <= 1'b0;
        end else begin
            out_line_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (in_line_start) begin
                        if (in_line_len != '0) begin
                            out_addr      <= in_base_addr;
                            rem           <= in_line_len;
                            out_line_busy <= 1'b1;
                            state         <= S_ISSUE;
                        end else begin
                            out_line_done <= 1'b1;
                        end
                    end
                end
                S_ISSUE: begin
                    // Strobe only once the controller is idle and a FIFO slot is free.
                    if (out_start_n) begin
                        if (in_busy_n && has_space) begin
                            out_start_n <= 1'b0;
                        end
                    end else if (!in_busy_n) begin
                        out_start_n <= 1'b1;
                        state       <= S_ACK_WAIT;
                    end
                end
                S_ACK_WAIT: begin
                    out_start_n <= 1'b1;
                    if (in_busy_n) begin
                        state <= S_DONE_WAIT;
                    end
                end
                S_DONE_WAIT: begin
                    out_addr <= out_addr + 1'b1;
                    rem      <= rem - 1'b1;
                    if (rem == REM_ONE) begin
                        out_line_busy <= 1'b0;
                        out_line_done <= 1'b1;
                        state         <= S_IDLE;
                    end else if (level_nxt == DEPTH_L) begin
                        state <= S_STALL;
                    end else begin
                        state <= S_ISSUE;
                    end
                end
                S_STALL: begin
                    if (has_space) begin
                        state <= S_ISSUE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign out_pix_data   = mem[rd_ptr];
    assign out_pix_valid  = (level != '0);
    assign out_fifo_level = level;
    assign out_rw         = 1'b1;
    assign out_fast_write = 1'b0;
    assign out_wr_data    = 16'h0000;
    assign out_dbg_state  = state;

endmodule

// File: tb/tb_amiv_sram_line_fetch.sv
// Directed bench for amiv_sram_line_fetch: SRAM controller model returning data = address,
// queued expected request addresses and pixel words, and a popping monitor.
module tb_amiv_sram_line_fetch;

    localparam int FIFO_DEPTH = 16;
    localparam int LEN_W      = 11;
    localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

    logic              in_clk;
    logic              in_reset;
    logic              in_line_start;
    logic [18:0]       in_base_addr;
    logic [LEN_W-1:0]  in_line_len;
    logic              out_line_busy;
    logic              out_line_done;
    logic              in_pop;
    logic [15:0]       out_pix_data;
    logic              out_pix_valid;
    logic [LVL_W-1:0]  out_fifo_level;
    logic              out_underrun;
    logic              out_start_n;
    logic              out_rw;
    logic              out_fast_write;
    logic [18:0]       out_addr;
    logic [15:0]       out_wr_data;
    logic              in_busy_n;
    logic [15:0]       in_rd_data;
    logic [2:0]        out_dbg_state;

    amiv_sram_line_fetch #(.FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)) dut (
        .in_clk         (in_clk),
        .in_reset       (in_reset),
        .in_line_start  (in_line_start),
        .in_base_addr   (in_base_addr),
        .in_line_len    (in_line_len),
        .out_line_busy  (out_line_busy),
        .out_line_done  (out_line_done),
        .in_pop         (in_pop),
        .out_pix_data   (out_pix_data),
        .out_pix_valid  (out_pix_valid),
        .out_fifo_level (out_fifo_level),
        .out_underrun   (out_underrun),
        .out_start_n    (out_start_n),
        .out_rw         (out_rw),
        .out_fast_write (out_fast_write),
        .out_addr       (out_addr),
        .out_wr_data    (out_wr_data),
        .in_busy_n      (in_busy_n),
        .in_rd_data     (in_rd_data),
        .out_dbg_state  (out_dbg_state)
    );

    int          checks = 0;
    int          failures = 0;
    logic [15:0] exp_q[$];
    logic [18:0] exp_addr_q[$];
    logic        pop_en = 1'b0;
    logic        pop_once = 1'b0;
    int          req_cnt = 0;
    int          win_cnt = 0;
    int          done_cnt = 0;
    int          und_cnt = 0;

    // Clock / reset
    initial begin
        in_clk = 1'b0;
        forever #5 in_clk = ~in_clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // SRAM controller model: acknowledges a strobe, stays busy 3 cycles, returns data = address.
    initial begin : ctl_model
        int          ctl_cnt;
        logic [18:0] ctl_addr;
        logic        prev_start_n;
        ctl_cnt      = 0;
        ctl_addr     = '0;
        prev_start_n = 1'b1;
        in_busy_n    = 1'b1;
        in_rd_data   = '0;
        forever begin
            @(negedge in_clk);
            if (prev_start_n && !out_start_n) win_cnt++;
            prev_start_n = out_start_n;
            if (ctl_cnt == 0) begin
                if (in_busy_n && !out_start_n) begin
                    req_cnt++;
                    if (exp_addr_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_request: got addr 0x%0h expected none", out_addr);
                    end else begin
                        chk("req_addr", 32'(out_addr), 32'(exp_addr_q.pop_front()));
                    end
                    ctl_addr  = out_addr;
                    in_busy_n = 1'b0;
                    ctl_cnt   = 3;
                end
            end else begin
                ctl_cnt--;
                if (ctl_cnt == 0) begin
                    in_rd_data = ctl_addr[15:0];
                    in_busy_n  = 1'b1;
                end
            end
        end
    end

    // Monitor: drives the pop and scores every word the DUT hands over.
    initial begin : monitor
        in_pop = 1'b0;
        forever begin
            @(negedge in_clk);
            if (out_line_done) done_cnt++;
            if (out_underrun) und_cnt++;
            in_pop   = pop_en | pop_once;
            pop_once = 1'b0;
            if (in_pop && out_pix_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word: got 0x%0h expected none", out_pix_data);
                end else begin
                    chk("pix_data", 32'(out_pix_data), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    // Driver tasks
    task automatic tick();
        @(posedge in_clk);
        #2;
    endtask

    task automatic start_line(input logic [18:0] base, input logic [LEN_W-1:0] len);
        in_base_addr  = base;
        in_line_len   = len;
        in_line_start = 1'b1;
        tick();
        in_line_start = 1'b0;
    endtask

    task automatic queue_line(input logic [18:0] base, input int len);
        logic [18:0] a;
        for (int i = 0; i < len; i++) begin
            a = base + 19'(i);
            exp_addr_q.push_back(a);
            exp_q.push_back(a[15:0]);
        end
    endtask

    task automatic wait_line(input string name, input int max_cycles);
        logic ok;
        ok = 1'b0;
        for (int n = 0; n < max_cycles; n++) begin
            if (!out_line_busy && exp_q.size() == 0 && exp_addr_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    initial begin : stimulus
        int r0, w0, d0, u0, bad;
        logic found;
        in_reset      = 1'b1;
        in_line_start = 1'b0;
        in_base_addr  = '0;
        in_line_len   = '0;
        repeat (3) tick();
        chk("rst_start_n", 32'(out_start_n), 32'd1);
        chk("rst_addr", 32'(out_addr), 32'd0);
        chk("rst_busy", 32'(out_line_busy), 32'd0);
        chk("rst_done", 32'(out_line_done), 32'd0);
        chk("rst_underrun", 32'(out_underrun), 32'd0);
        chk("rst_valid", 32'(out_pix_valid), 32'd0);
        chk("rst_level", 32'(out_fifo_level), 32'd0);
        chk("rst_rw", 32'(out_rw), 32'd1);
        chk("rst_fast_write", 32'(out_fast_write), 32'd0);
        chk("rst_wr_data", 32'(out_wr_data), 32'd0);
        in_reset = 1'b0;

        bad = 0;
        repeat (20) begin
            tick();
            if (!out_start_n || out_pix_valid || out_fifo_level != '0) bad++;
        end
        chk("idle_quiet", 32'(bad), 32'd0);

        // Basic line, consumer always ready
        pop_en = 1'b1;
        r0 = req_cnt; w0 = win_cnt; d0 = done_cnt;
        queue_line(19'h00100, 4);
        start_line(19'h00100, 11'd4);
        wait_line("basic_complete", 400);
        repeat (2) tick();
        chk("basic_req", 32'(req_cnt - r0), 32'd4);
        chk("basic_windows", 32'(win_cnt - w0), 32'd4);
        chk("basic_done", 32'(done_cnt - d0), 32'd1);
        chk("basic_busy", 32'(out_line_busy), 32'd0);

        // Backpressure: FIFO fills, fetcher stalls, then drains
        pop_en = 1'b0;
        repeat (3) tick();
        r0 = req_cnt; d0 = done_cnt;
        queue_line(19'h00200, 40);
        start_line(19'h00200, 11'd40);
        repeat (300) tick();
        chk("bp_req", 32'(req_cnt - r0), 32'd16);
        chk("bp_level", 32'(out_fifo_level), 32'd16);
        chk("bp_start_n", 32'(out_start_n), 32'd1);
        chk("bp_state", 32'(out_dbg_state), 32'd4);
        chk("bp_busy", 32'(out_line_busy), 32'd1);
        pop_en = 1'b1;
        wait_line("bp_complete", 2000);
        chk("bp_req_total", 32'(req_cnt - r0), 32'd40);
        chk("bp_done", 32'(done_cnt - d0), 32'd1);

        // Address wrap at the top of the 19-bit space
        r0 = req_cnt;
        queue_line(19'h7FFFE, 4);
        start_line(19'h7FFFE, 11'd4);
        wait_line("wrap_complete", 400);
        chk("wrap_req", 32'(req_cnt - r0), 32'd4);

        // Zero-length line
        repeat (2) tick();
        r0 = req_cnt; w0 = win_cnt; d0 = done_cnt;
        start_line(19'h01234, 11'd0);
        repeat (5) tick();
        chk("len0_done", 32'(done_cnt - d0), 32'd1);
        chk("len0_req", 32'(req_cnt - r0), 32'd0);
        chk("len0_windows", 32'(win_cnt - w0), 32'd0);
        chk("len0_busy", 32'(out_line_busy), 32'd0);

        // line_start while busy must be ignored
        r0 = req_cnt; d0 = done_cnt;
        queue_line(19'h00300, 8);
        start_line(19'h00300, 11'd8);
        repeat (5) tick();
        start_line(19'h00400, 11'd3);
        wait_line("ignore_complete", 800);
        repeat (50) tick();
        chk("ignore_req", 32'(req_cnt - r0), 32'd8);
        chk("ignore_done", 32'(done_cnt - d0), 32'd1);

        // Pop while empty
        pop_en = 1'b0;
        repeat (3) tick();
        u0 = und_cnt;
        pop_once = 1'b1;
        repeat (4) tick();
        chk("underrun_pulses", 32'(und_cnt - u0), 32'd1);
        chk("underrun_level", 32'(out_fifo_level), 32'd0);
        chk("underrun_valid", 32'(out_pix_valid), 32'd0);

        // Reset during ACK_WAIT of word 3 of 8
        pop_en = 1'b1;
        r0 = req_cnt;
        exp_addr_q.push_back(19'h00500);
        exp_addr_q.push_back(19'h00501);
        exp_addr_q.push_back(19'h00502);
        exp_q.push_back(16'h0500);
        exp_q.push_back(16'h0501);
        start_line(19'h00500, 11'd8);
        found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            if ((req_cnt - r0) == 3 && out_dbg_state == 3'd2) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("mid_reached_ack_wait", 32'(found), 32'd1);
        in_reset = 1'b1;
        tick();
        chk("mid_start_n", 32'(out_start_n), 32'd1);
        chk("mid_level", 32'(out_fifo_level), 32'd0);
        chk("mid_state", 32'(out_dbg_state), 32'd0);
        chk("mid_busy", 32'(out_line_busy), 32'd0);
        tick();
        in_reset = 1'b0;
        found = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (in_busy_n) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        chk("mid_ctl_finished", 32'(found), 32'd1);
        repeat (5) tick();
        chk("mid_late_level", 32'(out_fifo_level), 32'd0);
        chk("mid_late_valid", 32'(out_pix_valid), 32'd0);
        chk("mid_words_left", 32'(exp_q.size()), 32'd0);
        r0 = req_cnt;
        queue_line(19'h00600, 3);
        start_line(19'h00600, 11'd3);
        wait_line("post_reset_complete", 400);
        chk("post_reset_req", 32'(req_cnt - r0), 32'd3);

        repeat (5) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
